// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit FIFO controller.
package uart_pkg;

  localparam int BYTE_W = 8;

  // Drain sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_START,
    S_WBUSY,
    S_WDONE,
    S_GAP
  } state_t;

  // Write-port requester ids
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_MON = 1'b1
  } req_id_t;

  // One producer's write request
  typedef struct packed {
    logic              req;
    logic [BYTE_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/uart_wr_arb.sv
// Two-requester round-robin write arbiter with monitor lock.
// Grant is combinational; rr_last remembers the most recent winner.
module uart_wr_arb
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  wr_req_t           cpu,
  input  wr_req_t           mon,
  input  logic              mon_lock,
  input  logic              fifo_full,
  output logic              cpu_ack,
  output logic              mon_ack,
  output logic              fifo_wr,
  output logic [BYTE_W-1:0] fifo_din
);

  req_id_t rr_last;
  req_id_t winner;
  logic    cpu_cand;
  logic    mon_cand;
  logic    grant;

  // Pick a winner; the lock hides the CPU, ties go to whoever did not win last.
  // Grants are held off while reset is asserted so acks drop immediately.
  always_comb begin
    cpu_cand = cpu.req && !mon_lock;
    mon_cand = mon.req;
    grant    = reset && !fifo_full && (cpu_cand || mon_cand);
    if (cpu_cand && mon_cand)
      winner = (rr_last == REQ_MON) ? REQ_CPU : REQ_MON;
    else if (mon_cand)
      winner = REQ_MON;
    else
      winner = REQ_CPU;
    cpu_ack  = grant && (winner == REQ_CPU);
    mon_ack  = grant && (winner == REQ_MON);
    fifo_wr  = grant;
    fifo_din = '0;
    if (grant)
      fifo_din = (winner == REQ_CPU) ? cpu.data : mon.data;
  end

  // Track the last granted requester; starts as MON so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_last <= REQ_MON;
    else if (grant)
      rr_last <= winner;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit FIFO controller: write arbitration plus a
// read/load/transmit drain sequencer with flow control and inter-byte gap.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int IDLE_GAP = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [BYTE_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              mon_req,
  input  logic [BYTE_W-1:0] mon_data,
  input  logic              mon_lock,
  output logic              mon_ack,
  output logic              fifo_wr,
  output logic [BYTE_W-1:0] fifo_din,
  input  logic              fifo_full,
  output logic              fifo_rd,
  input  logic [BYTE_W-1:0] fifo_dout,
  input  logic              fifo_data_ready,
  input  logic              tx_en,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic [CNT_W-1:0]  tx_count,
  output logic              sched_busy
);

  // Gap counter holds IDLE_GAP-1 down to 0, so IDLE_GAP cycles are spent in S_GAP.
  localparam int GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam int GAP_LOAD = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

  state_t           state;
  state_t           state_nx;
  logic [GAP_W-1:0] gap_cnt;
  wr_req_t          cpu_w;
  wr_req_t          mon_w;

  assign cpu_w = '{req: cpu_req, data: cpu_data};
  assign mon_w = '{req: mon_req, data: mon_data};

  // The arbiter is independent of the sequencer: writes and reads may coincide.
  uart_wr_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .cpu      (cpu_w),
    .mon      (mon_w),
    .mon_lock (mon_lock),
    .fifo_full(fifo_full),
    .cpu_ack  (cpu_ack),
    .mon_ack  (mon_ack),
    .fifo_wr  (fifo_wr),
    .fifo_din (fifo_din)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Next state; tx_en is only consulted when leaving S_IDLE so a byte in flight always completes
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (fifo_data_ready && tx_en) state_nx = S_READ;
      S_READ:  state_nx = S_START;
      S_START: state_nx = S_WBUSY;
      S_WBUSY: if (tx_busy) state_nx = S_WDONE;
      S_WDONE: if (!tx_busy) state_nx = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == '0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Sequencer strobes; fifo_rd is gated by reset so it drops as soon as reset asserts
  always_comb begin
    fifo_rd    = reset && (state == S_IDLE) && fifo_data_ready && tx_en;
    tx_start   = (state == S_START);
    sched_busy = (state != S_IDLE);
  end

  // Datapath: byte capture, hand-off counter and gap countdown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data  <= '0;
      tx_count <= '0;
      gap_cnt  <= '0;
    end else begin
      if (state == S_READ)
        tx_data <= fifo_dout;
      if (state == S_START)
        tx_count <= tx_count + 1'b1;
      if (state == S_WDONE && !tx_busy)
        gap_cnt <= GAP_W'(GAP_LOAD);
      else if (state == S_GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule
